alu_result_bcd: RTL and testbench

//  Downstream stage of the 8-function ALU. Takes the 6-bit ALU result under a valid/ready handshake.

---
 rtl/alu_bcd_pkg.sv | 27 ++
 rtl/alu_result_bcd_if.sv | 24 ++
 rtl/bcd_add3.sv | 12 +
 rtl/alu_result_bcd.sv | 116 +++++++++++
 tb/tb_alu_result_bcd.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_bcd_pkg.sv
// Shared types and constants for the ALU result BCD stage.
// State encoding, add-3 constants and digit sizing.
package alu_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [3:0] BCD_ADD_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD_VAL    = 4'd3;

  // Decimal digits needed to show 2**w-1.
  function automatic int bcd_digits(input int w);
    longint m;
    int     d;
    m = (longint'(1) << w) - 1;
    d = 1;
    while (m > 9) begin
      m = m / 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_result_bcd_if.sv
// Input and output valid/ready channels of the BCD stage.
// master drives in_data/in_valid/out_ready, slave is the stage.
interface alu_result_bcd_if #(
  parameter int DATA_W = 6,
  parameter int DIGITS = 2
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic                out_sign;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bcd, out_sign, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bcd, out_sign, out_valid
  );
endinterface

// File: rtl/bcd_add3.sv
// Per-nibble double-dabble correction.
// Nibbles of 5 or more get +3, others pass through.
module bcd_add3
  import alu_bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADD_THRESH) ? d + BCD_ADD_VAL : d;

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential double-dabble of the ALU result, one bit per clock.
// Define ALU_BCD_SIGN_EN for two's complement input with sign out.
module alu_result_bcd
  import alu_bcd_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DIGITS = bcd_digits(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_bcd_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] bin;
  logic [DATA_W-1:0] bin_n;
  logic [DATA_W-1:0] mag;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     bcd_n;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     obcd;
  logic              ordy;
  logic              oval;
  logic              last;
  logic              take;

  assign take = (state == ST_IDLE) && bus.in_valid;
  assign last = (state == ST_SHIFT) && (cnt == CW'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add
    bcd_add3 u_add (
      .d(bcd[4*g +: 4]),
      .q(adj[4*g +: 4])
    );
  end

  assign bcd_n = {adj[BW-2:0], bin[DATA_W-1]};
  assign bin_n = {bin[DATA_W-2:0], 1'b0};

`ifdef ALU_BCD_SIGN_EN
  logic neg;
  logic sgn;
  logic osign;

  assign neg = bus.in_data[DATA_W-1];
  assign mag = neg ? -bus.in_data : bus.in_data;

  // Sign captured at accept, published with the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn   <= 1'b0;
      osign <= 1'b0;
    end else begin
      if (take) sgn <= neg;
      if (last) osign <= sgn;
    end
  end

  assign bus.out_sign = osign;
`else
  assign mag = bus.in_data;
  assign bus.out_sign = 1'b0;
`endif

  // Control FSM with shift/count datapath and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      obcd  <= '0;
      ordy  <= 1'b1;
      oval  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            bin   <= mag;
            bcd   <= '0;
            cnt   <= CW'(DATA_W);
            ordy  <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bin <= bin_n;
          bcd <= bcd_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            obcd  <= bcd_n;
            oval  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            oval  <= 1'b0;
            ordy  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ordy;
  assign bus.out_valid = oval;
  assign bus.out_bcd   = obcd;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Scoreboard bench for alu_result_bcd.
// Expected {sign,bcd} queued at accept, checked by the monitor.
module tb_alu_result_bcd;

`ifdef ALU_BCD_SIGN_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_result_bcd_if #(.DATA_W(6), .DIGITS(2)) bus ();

  alu_result_bcd #(.DATA_W(6), .DIGITS(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  logic       prev_val = 1'b0;
  logic [8:0] sb[$];
  logic [8:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout required event", nm);
  endtask

  // Monitor: latency on each rise, compare on each handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !prev_val)
      chk("latency", 16'(cyc - acc_cyc), 16'd6);
    prev_val = bus.out_valid;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %0h required none",
                 bus.out_bcd);
      end else begin
        e = sb.pop_front();
        chk("out_bcd", 16'(bus.out_bcd), 16'(e[7:0]));
        chk("out_sign", 16'(bus.out_sign), 16'(e[8]));
      end
    end
  end

  task automatic send(input logic [5:0] d,
                      input logic [8:0] x,
                      input bit push);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.in_ready) begin
        if (push) sb.push_back(x);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) fail("accept_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid || !bus.in_ready)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout");
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_bcd", 16'(bus.out_bcd), 16'h00);
    chk("rst_out_sign", 16'(bus.out_sign), 16'd0);
    rst_n = 1'b1;

    // full scale
    send(6'd63, SGN ? 9'h101 : 9'h063, 1'b1);
    drain();

    // zero and digit boundaries, back to back
    send(6'd0, 9'h000, 1'b1);
    send(6'd9, 9'h009, 1'b1);
    send(6'd10, 9'h010, 1'b1);
    drain();

    // backpressure
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(6'd45, SGN ? 9'h119 : 9'h045, 1'b1);
    for (int i = 0; i < 50 && !bus.out_valid; i++)
      @(negedge clk);
    if (!bus.out_valid) fail("bp_valid_timeout");
    bus.in_data  = 6'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_bcd", 16'(bus.out_bcd), SGN ? 16'h19 : 16'h45);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      chk("bp_valid", 16'(bus.out_valid), 16'd1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_store", 16'(bus.in_ready), 16'd1);
    end

    // reset during the third shift cycle
    send(6'd50, 9'h000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_in_ready", 16'(bus.in_ready), 16'd1);
    chk("mid_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_out_bcd", 16'(bus.out_bcd), 16'h00);
    chk("mid_out_sign", 16'(bus.out_sign), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(6'd17, 9'h017, 1'b1);
    drain();

    // sign handling (or unsigned view of the same codes)
    send(6'b111110, SGN ? 9'h102 : 9'h062, 1'b1);
    send(6'b100000, SGN ? 9'h132 : 9'h032, 1'b1);
    send(6'd31, 9'h031, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
